// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types: physical register file sizing and
// free-list pointer geometry, imported by rename, ROB and free-list logic.
package rename_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH) + 1;

  typedef logic [PREG_W-1:0] preg_t;

  // p0 is hard-wired and never circulates through the free list
  function automatic logic preg_legal(input preg_t p);
    return (p != preg_t'(0)) && ({1'b0, p} < (PREG_W+1)'(NUM_PREGS));
  endfunction

endpackage

// File: rtl/preg_free_list_ctrl_fl_ptr_adv.sv
// Advances a wrap-bit free-list pointer by 0..RETIRE_W entries; the natural
// overflow of the FL_PTR_W-bit sum gives the modulo-2D wrap.
module fl_ptr_adv
  import rename_pkg::*;
#(
  parameter int INC_W = 2
) (
  input  logic [FL_PTR_W-1:0] ptr,
  input  logic [INC_W-1:0]    inc,
  output logic [FL_PTR_W-1:0] ptr_next
);

  assign ptr_next = ptr + FL_PTR_W'(inc);

endmodule

// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list: speculative/committed heads, multi-slot retire
// push, flush restore. Optional checking and err output under FREELIST_CHECK_EN.
module preg_free_list_ctrl
  import rename_pkg::*;
#(
  parameter int RETIRE_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_req,
  output logic                       alloc_gnt,
  output logic [PREG_W-1:0]          alloc_preg,
  input  logic [RETIRE_W-1:0]        ret_valid,
  input  logic [RETIRE_W*PREG_W-1:0] ret_old_preg,
  input  logic                       flush,
  output logic                       stall,
  output logic [PREG_W:0]            free_count
`ifdef FREELIST_CHECK_EN
  ,
  output logic                       err
`endif
);

  localparam int IDX_W = FL_PTR_W - 1;
  localparam int CNT_W = $clog2(RETIRE_W + 1);

  preg_t                mem_r [FL_DEPTH];
  logic [FL_PTR_W-1:0]  spec_head_r;
  logic [FL_PTR_W-1:0]  commit_head_r;
  logic [FL_PTR_W-1:0]  tail_r;
  logic [FL_PTR_W-1:0]  occ_s;
  logic [FL_PTR_W-1:0]  tail_nxt_s;
  logic [FL_PTR_W-1:0]  commit_nxt_s;
  logic [FL_PTR_W-1:0]  spec_nxt_s;
  logic [CNT_W-1:0]     push_cnt_s;
  logic [RETIRE_W-1:0]  slot_ok_s;
  logic [RETIRE_W-1:0]  slot_bad_s;
  logic [RETIRE_W-1:0]  slot_ovf_s;
  preg_t                slot_preg_s [RETIRE_W];
  logic [IDX_W-1:0]     slot_addr_s [RETIRE_W];

  // Free count and stall come from registered pointers only: no retire bypass
  assign occ_s      = tail_r - spec_head_r;
  assign free_count = (PREG_W+1)'(occ_s);
  assign stall      = (occ_s == '0);
  assign alloc_gnt  = alloc_req & ~stall & ~flush;
  assign alloc_preg = mem_r[spec_head_r[IDX_W-1:0]];

  // Slot-ordered retire push; overflow is judged against the speculative head
  always_comb begin
    push_cnt_s = '0;
    slot_ok_s  = '0;
    slot_bad_s = '0;
    slot_ovf_s = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      slot_preg_s[i] = ret_old_preg[i*PREG_W +: PREG_W];
      slot_addr_s[i] = tail_r[IDX_W-1:0] + IDX_W'(push_cnt_s);
      if (!ret_valid[i]) begin
        slot_ok_s[i] = 1'b0;
      end else if (!preg_legal(slot_preg_s[i])) begin
        slot_bad_s[i] = 1'b1;
      end else if (((FL_PTR_W+1)'(occ_s) + (FL_PTR_W+1)'(push_cnt_s)) >= (FL_PTR_W+1)'(FL_DEPTH)) begin
        slot_ovf_s[i] = 1'b1;
      end else begin
        slot_ok_s[i] = 1'b1;
        push_cnt_s   = push_cnt_s + CNT_W'(1);
      end
    end
  end

  fl_ptr_adv #(.INC_W(CNT_W)) u_tail_adv (
    .ptr      (tail_r),
    .inc      (push_cnt_s),
    .ptr_next (tail_nxt_s)
  );

  fl_ptr_adv #(.INC_W(CNT_W)) u_commit_adv (
    .ptr      (commit_head_r),
    .inc      (push_cnt_s),
    .ptr_next (commit_nxt_s)
  );

  // Flush rewinds the speculative head onto the post-retire committed head
  always_comb begin
    if (flush) begin
      spec_nxt_s = commit_nxt_s;
    end else begin
      spec_nxt_s = spec_head_r + FL_PTR_W'(alloc_gnt);
    end
  end

  // Pointer and storage update; reset reloads p32..p63 and drops any retire
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head_r   <= '0;
      commit_head_r <= '0;
      tail_r        <= FL_PTR_W'(FL_DEPTH);
      for (int k = 0; k < FL_DEPTH; k++) begin
        mem_r[k] <= PREG_W'(NUM_AREGS + k);
      end
    end else begin
      spec_head_r   <= spec_nxt_s;
      commit_head_r <= commit_nxt_s;
      tail_r        <= tail_nxt_s;
      for (int i = 0; i < RETIRE_W; i++) begin
        if (slot_ok_s[i]) begin
          mem_r[slot_addr_s[i]] <= slot_preg_s[i];
        end
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  logic                err_r;
  logic [RETIRE_W-1:0] slot_dup_s;

  assign err = err_r;

  // Double-free detection: compare each push against every live free entry
  always_comb begin
    slot_dup_s = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        if (slot_ok_s[i] && (mem_r[k] == slot_preg_s[i]) &&
            ({1'b0, IDX_W'(k) - spec_head_r[IDX_W-1:0]} < occ_s)) begin
          slot_dup_s[i] = 1'b1;
        end else begin
          slot_dup_s[i] = slot_dup_s[i];
        end
      end
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      for (int i = 0; i < RETIRE_W; i++) begin
        if (slot_bad_s[i] | slot_ovf_s[i] | slot_dup_s[i]) begin
          $error("free list protocol error: slot %0d preg %0d", i, slot_preg_s[i]);
        end
      end
      err_r <= err_r | (|slot_bad_s) | (|slot_ovf_s) | (|slot_dup_s);
    end
  end
`endif

endmodule
